// File: rtl/mfsk_modulator.sv
// mfsk_modulator -- parametrised M-ary FSK modulator.
//
// Accepts WORD_W-bit code words over a valid/ready handshake, splits each
// word into BITS_PER_SYM-bit symbols (MSB first) and emits every symbol for
// SYM_CYCLES clocks as a square wave with half-period
// H(k) = BASE_HALF - k*HALF_STEP clocks, where k is the symbol value.
//
// Optional feature: define MFSK_PREAMBLE_EN to emit PRE_SYMS preamble
// symbols (tone 0 / tone M-1 alternating) after an accept from IDLE.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   in_data   in   code word to transmit
//   in_valid  in   in_data valid
//   in_ready  out  word accepted this cycle when in_valid is also high
//   fsk_out   out  modulated square-wave output
//   busy      out  high whenever not idle
//   tone_idx  out  tone currently being emitted (0 when idle)
module mfsk_modulator #(
  parameter int WORD_W       = 8,
  parameter int BITS_PER_SYM = 2,
  parameter int SYM_CYCLES   = 64,
  parameter int BASE_HALF    = 16,
  parameter int HALF_STEP    = 4,
  parameter int PRE_SYMS     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    fsk_out,
  output logic                    busy,
  output logic [BITS_PER_SYM-1:0] tone_idx
);

  localparam int NSYM = WORD_W / BITS_PER_SYM;
  localparam int SC_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int HC_W = (BASE_HALF > 1) ? $clog2(BASE_HALF) : 1;
  localparam int WC_W = (NSYM > 0) ? $clog2(NSYM + 1) : 1;

  // Elaboration-time parameter sanity checks.
  if (WORD_W % BITS_PER_SYM != 0) begin : g_chk_word
    $error("WORD_W must be a multiple of BITS_PER_SYM");
  end
  if (BITS_PER_SYM < 1 || BITS_PER_SYM > 3) begin : g_chk_bits
    $error("BITS_PER_SYM must be 1..3");
  end
  if (SYM_CYCLES < 2) begin : g_chk_sym
    $error("SYM_CYCLES must be at least 2");
  end
  if (BASE_HALF - ((1 << BITS_PER_SYM) - 1) * HALF_STEP < 1) begin : g_chk_half
    $error("highest tone half-period must be at least 1");
  end
  if (PRE_SYMS < 1) begin : g_chk_pre
    $error("PRE_SYMS must be at least 1");
  end

`ifdef MFSK_PREAMBLE_EN
  localparam int PRE_W = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SEND} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q;
  logic [SC_W-1:0]   sym_cnt_q;
  logic [HC_W-1:0]   half_cnt_q;
  logic [WC_W-1:0]   wsym_q;
  logic              fsk_q;
`ifdef MFSK_PREAMBLE_EN
  logic [PRE_W-1:0]  pre_q;
  logic              pre_last;
`endif

  logic              sym_end;
  logic              word_last;
  logic              accept;
  logic [HC_W-1:0]   half_last;
  logic              half_hit;

  assign sym_end   = (sym_cnt_q == SC_W'(SYM_CYCLES - 1));
  assign word_last = (wsym_q == WC_W'(NSYM - 1));
`ifdef MFSK_PREAMBLE_EN
  assign pre_last  = (pre_q == PRE_W'(PRE_SYMS - 1));
`endif

  // Terminal count of the half-period counter for the tone on air now.
  assign half_last = HC_W'(BASE_HALF - 1 - int'(tone_idx) * HALF_STEP);
  assign half_hit  = (half_cnt_q == half_last);

  assign accept  = in_valid & in_ready;
  assign busy    = (state_q != S_IDLE);
  assign fsk_out = fsk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    tone_idx = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MFSK_PREAMBLE_EN
          state_d = S_PRE;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef MFSK_PREAMBLE_EN
      S_PRE: begin
        tone_idx = pre_q[0] ? '1 : '0;
        if (sym_end && pre_last) begin
          state_d = S_SEND;
        end
      end
`endif
      S_SEND: begin
        tone_idx = shreg_q[WORD_W-1 -: BITS_PER_SYM];
        // Last cycle of the word doubles as the back-to-back accept slot.
        if (sym_end && word_last) begin
          in_ready = 1'b1;
          if (!in_valid) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q    <= '0;
      sym_cnt_q  <= '0;
      half_cnt_q <= '0;
      wsym_q     <= '0;
      fsk_q      <= 1'b0;
`ifdef MFSK_PREAMBLE_EN
      pre_q      <= '0;
`endif
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        shreg_q    <= in_data;
        sym_cnt_q  <= '0;
        half_cnt_q <= '0;
        wsym_q     <= '0;
        fsk_q      <= 1'b1;
`ifdef MFSK_PREAMBLE_EN
        pre_q      <= '0;
`endif
      end
    end else begin
      // Half-period counter restarts on a toggle and on every symbol
      // boundary; the output level itself is carried across boundaries.
      if (half_hit || sym_end) begin
        half_cnt_q <= '0;
      end else begin
        half_cnt_q <= half_cnt_q + 1'b1;
      end
      if (half_hit) begin
        fsk_q <= ~fsk_q;
      end

      if (sym_end) begin
        sym_cnt_q <= '0;
      end else begin
        sym_cnt_q <= sym_cnt_q + 1'b1;
      end

      if (sym_end) begin
        if (state_q == S_SEND) begin
          if (!word_last) begin
            shreg_q <= shreg_q << BITS_PER_SYM;
            wsym_q  <= wsym_q + 1'b1;
          end else begin
            wsym_q <= '0;
            if (accept) begin
              shreg_q <= in_data;
            end else begin
              fsk_q <= 1'b0;
            end
          end
        end
`ifdef MFSK_PREAMBLE_EN
        if (state_q == S_PRE) begin
          pre_q <= pre_last ? '0 : pre_q + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mfsk_modulator.sv
module tb_mfsk_modulator;

  logic       clk;
  logic       reset;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       fsk_out;
  logic       busy;
  logic [1:0] tone_idx;

  logic [3:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic       fsk_out2;
  logic       busy2;
  logic [0:0] tone_idx2;

  int checks   = 0;
  int failures = 0;

  mfsk_modulator dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fsk_out  (fsk_out),
    .busy     (busy),
    .tone_idx (tone_idx)
  );

  mfsk_modulator #(
    .WORD_W       (4),
    .BITS_PER_SYM (1),
    .SYM_CYCLES   (8),
    .BASE_HALF    (4),
    .HALF_STEP    (2),
    .PRE_SYMS     (4)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data2),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .fsk_out  (fsk_out2),
    .busy     (busy2),
    .tone_idx (tone_idx2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid2 = 1'b0;
    in_data2  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_hold: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               fsk_out, busy, in_ready, tone_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
                 k, fsk_out, busy, in_ready, tone_idx);
      end
      checks++;
      if ({fsk_out2, busy2, in_ready2, tone_idx2} !== 4'b0010) begin
        failures++;
        $display("FAIL reset_idle2[%0d]: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
                 k, fsk_out2, busy2, in_ready2, tone_idx2);
      end
    end
  endtask

  // Offers word w to dut (ending on a negedge), then checks 256 cycles
  // of symbols and the return to idle.
  task automatic test_single_word(input logic [7:0] w, input string name);
    logic       lvl;
    logic [1:0] et;
    int         h;
    int         sh;
    in_data  = w;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lvl = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      sh = 6 - 2 * (k / 64);
      et = 2'((w >> sh) & 8'h03);
      checks++;
      if (busy !== 1'b1 || tone_idx !== et) begin
        failures++;
        $display("FAIL %s_tone[%0d]: got busy=%b tone=%0d want busy=1 tone=%0d",
                 name, k, busy, tone_idx, et);
      end
      checks++;
      if (fsk_out !== lvl) begin
        failures++;
        $display("FAIL %s_fsk[%0d]: got %b want %b", name, k, fsk_out, lvl);
      end
      checks++;
      if (in_ready !== (k == 255)) begin
        failures++;
        $display("FAIL %s_ready[%0d]: got %b want %b", name, k, in_ready, (k == 255));
      end
      h = 16 - 4 * int'(et);
      if (((k % 64) % h) == h - 1) lvl = ~lvl;
    end
    @(negedge clk);
    checks++;
    if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
      failures++;
      $display("FAIL %s_end: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               name, fsk_out, busy, in_ready, tone_idx);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    test_single_word(8'b00_01_10_11, "single");
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    logic       lvl;
    logic [1:0] et;
    int         h;
    int         sh;
    @(negedge clk);
    in_data  = 8'hE4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h1B;
    lvl = 1'b1;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      w  = (k < 256) ? 8'hE4 : 8'h1B;
      sh = 6 - 2 * ((k % 256) / 64);
      et = 2'((w >> sh) & 8'h03);
      checks++;
      if (busy !== 1'b1 || tone_idx !== et) begin
        failures++;
        $display("FAIL b2b_tone[%0d]: got busy=%b tone=%0d want busy=1 tone=%0d",
                 k, busy, tone_idx, et);
      end
      checks++;
      if (fsk_out !== lvl) begin
        failures++;
        $display("FAIL b2b_fsk[%0d]: got %b want %b", k, fsk_out, lvl);
      end
      checks++;
      if (in_ready !== ((k % 256) == 255)) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", k, in_ready, ((k % 256) == 255));
      end
      h = 16 - 4 * int'(et);
      if (((k % 64) % h) == h - 1) lvl = ~lvl;
      if (k == 255) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
      failures++;
      $display("FAIL b2b_end: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               fsk_out, busy, in_ready, tone_idx);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_data  = 8'h1B;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tone_idx !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_pre: got busy=%b tone=%0d want busy=1 tone=1", busy, tone_idx);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
      failures++;
      $display("FAIL rstmid_async: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               fsk_out, busy, in_ready, tone_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({fsk_out, busy, in_ready, tone_idx} !== 5'b00100) begin
      failures++;
      $display("FAIL rstmid_idle: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               fsk_out, busy, in_ready, tone_idx);
    end
    test_single_word(8'hC0, "rstmid_fresh");
  endtask

  task automatic test_one_bit_symbols;
    logic [3:0] w;
    logic       lvl;
    logic       et;
    int         h;
    w = 4'b1010;
    @(negedge clk);
    in_data2  = w;
    in_valid2 = 1'b1;
    checks++;
    if (in_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL m2_ready_idle: got %b want 1", in_ready2);
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lvl = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      et = w[3 - k / 8];
      checks++;
      if (busy2 !== 1'b1 || tone_idx2 !== et) begin
        failures++;
        $display("FAIL m2_tone[%0d]: got busy=%b tone=%0d want busy=1 tone=%0d",
                 k, busy2, tone_idx2, et);
      end
      checks++;
      if (fsk_out2 !== lvl) begin
        failures++;
        $display("FAIL m2_fsk[%0d]: got %b want %b", k, fsk_out2, lvl);
      end
      h = 4 - 2 * int'(et);
      if (((k % 8) % h) == h - 1) lvl = ~lvl;
    end
    @(negedge clk);
    checks++;
    if ({fsk_out2, busy2, in_ready2, tone_idx2} !== 4'b0010) begin
      failures++;
      $display("FAIL m2_end: got fsk=%b busy=%b rdy=%b tone=%0d, want 0 0 1 0",
               fsk_out2, busy2, in_ready2, tone_idx2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_one_bit_symbols();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
